// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and default width for the serial adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder built from two half adders and an OR
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - 1-bit half adder
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);

    // One extra counter bit so the count can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int IDX_W = $clog2(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    // Holds the WIDTH-1 sum bits produced so far; the final bit comes
    // straight from the adder on the last RUN edge.
    logic [WIDTH-2:0]   sh_q;

    logic               bit_a;
    logic               bit_b;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sh_cat;
    logic               last_bit;

    assign bit_a    = a_q[cnt[IDX_W-1:0]];
    assign bit_b    = b_q[cnt[IDX_W-1:0]];
    assign sh_cat   = {fa_sum, sh_q};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    full_adder u_fa (
        .a    (bit_a),
        .b    (bit_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Controller FSM with operand capture, serial shift and result update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sh_q    <= '0;
            sum_o   <= '0;
            c_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= c_i;
                        cnt     <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    sh_q    <= sh_cat[WIDTH-1:1];
                    carry_q <= fa_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_o <= sh_cat;
                        c_o   <= fa_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = (state == LOAD) || (state == RUN);
    assign done_o  = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed and random checks for serial_adder_ctrl
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         c_i;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         c_o;

    int checks   = 0;
    int failures = 0;

    logic         mon_en = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_c;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         co;
    } vec_t;

    vec_t vecs [8];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .c_o     (c_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Result must hold between done pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done_o) begin
                held_sum = sum_o;
                held_c   = c_o;
            end else begin
                check("hold", {23'd0, c_o, sum_o}, {23'd0, held_c, held_sum});
            end
        end
    end

    // Starts one operation; optionally pulses start and scrambles operands after edge glitch_edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int glitch_edge,
                         output logic [W-1:0] s, output logic co, output int lat);
        @(negedge clk);
        a_i = a; b_i = b; c_i = cin; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = -1; s = '0; co = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == glitch_edge) begin
                start_i = 1'b1; a_i = ~a; b_i = ~b; c_i = ~cin;
            end
            if (k == glitch_edge + 1) start_i = 1'b0;
            @(negedge clk);
            if (done_o) begin
                lat = k; s = sum_o; co = c_o;
            end
        end
    endtask

    task automatic op_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input int glitch_edge,
                                input logic [W-1:0] es, input logic eco);
        logic [W-1:0] s;
        logic         co;
        int           lat;
        do_op(a, b, cin, glitch_edge, s, co, lat);
        check({name, "_latency"}, lat, W + 1);
        check({name, "_sum"}, s, es);
        check({name, "_cout"}, co, eco);
        @(negedge clk);
        check({name, "_ready_after"}, ready_o, 1'b1);
        check({name, "_busy_after"}, busy_o, 1'b0);
    endtask

    initial begin
        int           dpos [3];
        int           ndone;
        int           nready;
        logic         seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rexp;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        rst_i = 1'b1; start_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF; c_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("rst_ready", ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_sum", sum_o, 8'h00);
        check("rst_cout", c_o, 1'b0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_ready_before", i), ready_o, 1'b1);
            op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 0,
                         vecs[i].sum, vecs[i].co);
        end

        // start held high: three back-to-back operations
        @(negedge clk);
        a_i = 8'h21; b_i = 8'h43; c_i = 1'b1; start_i = 1'b1;
        @(posedge clk);
        ndone = 0; nready = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (ready_o) nready++;
            if (done_o) begin
                if (ndone < 3) dpos[ndone] = k;
                ndone++;
                check("held_sum", sum_o, 8'h65);
                check("held_cout", c_o, 1'b0);
            end
            @(posedge clk);
        end
        #1;
        start_i = 1'b0;
        check("held_done_count", ndone, 3);
        check("held_ready_count", nready, 2);
        if (ndone >= 3) begin
            check("held_first_done", dpos[0], W + 1);
            check("held_gap1", dpos[1] - dpos[0], W + 3);
            check("held_gap2", dpos[2] - dpos[1], W + 3);
        end
        repeat (2) @(negedge clk);

        // start pulse and operand change mid-RUN are ignored
        op_and_check("glitch", 8'h5A, 8'h3C, 1'b0, 4, 8'h96, 1'b0);
        repeat (3) @(negedge clk);
        check("glitch_no_requeue", busy_o, 1'b0);

        // reset after three bits consumed aborts cleanly
        @(negedge clk);
        a_i = 8'hC3; b_i = 8'h5A; c_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", busy_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("abort_ready", ready_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        check("abort_sum", sum_o, 8'h00);
        check("abort_cout", c_o, 1'b0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        op_and_check("after_abort", 8'hC3, 8'h5A, 1'b0, 0, 8'h1D, 1'b1);

        // random operations with result-hold monitor
        held_sum = sum_o;
        held_c   = c_o;
        mon_en   = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            op_and_check($sformatf("rand%0d", i), ra, rb, rc, 0, rexp[W-1:0], rexp[W]);
        end
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
